// File: rtl/temp_sensor_filter.sv
`default_nettype none
// ============================================================================
// temp_sensor_filter : moving-average filter with stale-sensor watchdog
// Rev 1.0
// ============================================================================
module temp_sensor_filter #(
  parameter int                 AVG_LOG2    = 2,
  parameter logic signed [7:0]  IDLE_TEMP   = 8'sd25,
  parameter int                 STALE_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              raw_valid,
  input  logic signed [7:0] raw_data,
  output logic signed [7:0] temp_o,
  output logic              temp_valid,
  output logic              fault_o
);

  localparam int N   = 1 << AVG_LOG2;
  localparam int SW  = 8 + AVG_LOG2;
  localparam int SCW = $clog2(STALE_LIMIT);

  localparam logic [SCW-1:0]      STALE_MAX = SCW'(STALE_LIMIT - 1);
  localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(N - 1);
  localparam logic signed [7:0]   ERR_CODE  = 8'h80;

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic signed [7:0]   win_mem [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2-1:0] fill;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_nxt;
  logic signed [SW-1:0] sum_shift;
  logic signed [SW-1:0] raw_ext;
  logic signed [SW-1:0] evict_ext;
  logic signed [7:0]   evict;
  logic signed [7:0]   avg_q;
  logic signed [7:0]   avg_nxt;
  logic [SCW-1:0]      stale;
  logic                accept;
  logic                timeout;

  assign accept  = raw_valid && (raw_data != ERR_CODE);
  assign timeout = (state != ST_FAULT) && !accept && (stale == STALE_MAX);

  // Only a full window (RUN) has a real entry to evict; while filling it counts as zero.
  assign evict     = (state == ST_RUN) ? win_mem[wr_ptr] : 8'sd0;
  assign raw_ext   = {{AVG_LOG2{raw_data[7]}}, raw_data};
  assign evict_ext = {{AVG_LOG2{evict[7]}}, evict};
  assign sum_nxt   = sum + raw_ext - evict_ext;
  assign sum_shift = sum_nxt >>> AVG_LOG2;
  assign avg_nxt   = sum_shift[7:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WARMUP: begin
        if (accept && (fill == FILL_LAST)) begin
          state_nxt = ST_RUN;
        end else if (timeout) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_RUN: begin
        if (timeout) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (accept) begin
          state_nxt = ST_WARMUP;
        end
      end
      default: state_nxt = ST_WARMUP;
    endcase
  end

  always_comb begin
    temp_o     = IDLE_TEMP;
    temp_valid = 1'b0;
    fault_o    = 1'b0;
    case (state)
      ST_RUN: begin
        temp_o     = avg_q;
        temp_valid = 1'b1;
      end
      ST_FAULT: begin
        fault_o = 1'b1;
      end
      default: begin
        temp_o = IDLE_TEMP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum    <= '0;
      fill   <= '0;
      wr_ptr <= '0;
      stale  <= '0;
      avg_q  <= IDLE_TEMP;
    end else if (timeout) begin
      sum    <= '0;
      fill   <= '0;
      wr_ptr <= '0;
      stale  <= '0;
    end else if (accept) begin
      sum    <= sum_nxt;
      wr_ptr <= wr_ptr + 1'b1;
      stale  <= '0;
      if (state != ST_RUN) begin
        fill <= fill + 1'b1;
      end
      if (state_nxt == ST_RUN) begin
        avg_q <= avg_nxt;
      end
    end else if ((state != ST_FAULT) && (stale != STALE_MAX)) begin
      stale <= stale + 1'b1;
    end
  end

  // Window storage needs no reset: entries are only read once the window is full.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_mem[wr_ptr] <= raw_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_temp_sensor_filter.sv
`default_nettype none
// ============================================================================
// tb_temp_sensor_filter : randomized scoreboard bench for temp_sensor_filter
// Rev 1.0
// ============================================================================
module tb_temp_sensor_filter;

  localparam int N    = 4;
  localparam int L    = 40;
  localparam int IDLE = 25;

  typedef struct packed {
    logic [7:0] t;
    logic       v;
    logic       f;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              raw_valid = 1'b0;
  logic signed [7:0] raw_data = 8'sd0;
  logic signed [7:0] temp_o;
  logic              temp_valid;
  logic              fault_o;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   win[$];
  bit   running = 1'b0;
  bit   faulted = 1'b0;
  int   idle_cnt = 0;
  int   m_temp = IDLE;

  temp_sensor_filter #(
    .AVG_LOG2   (2),
    .IDLE_TEMP  (8'sd25),
    .STALE_LIMIT(L)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .raw_valid (raw_valid),
    .raw_data  (raw_data),
    .temp_o    (temp_o),
    .temp_valid(temp_valid),
    .fault_o   (fault_o)
  );

  always #5 clk = ~clk;

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.t = running ? 8'(m_temp) : 8'(IDLE);
    e.v = running;
    e.f = faulted;
    return e;
  endfunction

  // Reference model: window as a queue of accepted samples, idle_cnt = cycles since last accept.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win.delete();
      running  = 1'b0;
      faulted  = 1'b0;
      idle_cnt = 0;
      q.delete();
      q.push_back(cur_exp());
    end else begin
      if (raw_valid && (raw_data != 8'sh80)) begin
        idle_cnt = 0;
        faulted  = 1'b0;
        win.push_back(int'(raw_data));
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          int s;
          s = 0;
          foreach (win[k]) s += win[k];
          running = 1'b1;
          m_temp  = floor_avg(s);
        end
      end else if (!faulted) begin
        if (idle_cnt == L - 1) begin
          faulted  = 1'b1;
          running  = 1'b0;
          win.delete();
          idle_cnt = 0;
        end else begin
          idle_cnt++;
        end
      end
      q.push_back(cur_exp());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty t=%0t: output present but no expectation queued", $time);
    end else begin
      e = q.pop_front();
      if ({temp_o, temp_valid, fault_o} !== {e.t, e.v, e.f}) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got temp_o=%0d valid=%0b fault=%0b, want temp_o=%0d valid=%0b fault=%0b",
                 $time, temp_o, temp_valid, fault_o, $signed(e.t), e.v, e.f);
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] d);
    raw_valid = v;
    raw_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b1, d);
    drive(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    rstn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    send(8'd80);
    send(8'h80);

    pulse_reset();
    send(8'hFF); send(8'h80); send(8'hFE); send(8'h80); send(8'hFE);
    drive(1'b1, 8'h80); drive(1'b1, 8'h80); send(8'hFE);

    idle(L);
    idle(3);
    send(8'd50); send(8'd50); send(8'd50); send(8'd50);

    drive(1'b1, 8'd60);
    idle(L - 1);
    drive(1'b1, 8'd70);
    idle(L - 2);
    repeat (3) drive(1'b1, 8'h80);
    idle(2);

    pulse_reset();
    send(8'd5); send(8'd6);
    pulse_reset();
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    send(8'd9); send(8'd9);
    pulse_reset();
    send(8'd100); send(8'd100); send(8'd100); send(8'd100);

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        pulse_reset();
      end else if (r < 5) begin
        idle(int'($urandom_range(L - 3, L + 2)));
      end else if (r < 40) begin
        drive(1'b1, ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom));
      end else begin
        drive(1'b0, 8'($urandom));
      end
    end

    drive(1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
